candy_sram_arbiter: RTL

Shares the single-port candy_sram between three requesters: instruction fetch (read), data load (read) and writeback (write). Each requester uses a req/ack handshake. The arbiter serialises accesses with a round-robin grant and drives the SRAM read/write strobes. It handles variable read latency through sram_rdata_ready and bounds it with a timeout. It sits between candy_if/candy_load/candy_wb and candy_sram, replacing their direct SRAM wiring.

---
 rtl/candy_sram_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/candy_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : candy_sram_arbiter
// Purpose  : Shares the single-port candy_sram between instruction fetch
//            (read), data load (read) and writeback (write). Requests are
//            granted round-robin, one SRAM access at a time. Read latency
//            is variable (sram_rdata_ready) and bounded by RD_TIMEOUT.
// Ports    : clk/rst             - clock, async active-high reset
//            if_* / ld_*         - read requesters (req/ack, addr, rdata)
//            wb_*                - write requester (req/ack, addr, wdata)
//            sram_*              - SRAM read/write strobes, address, data
//            rd_timeout          - pulses with the ack of an aborted read
//            busy                - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module candy_sram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              wb_ack,
  output logic              sram_read_enable,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_rdata_ready,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              rd_timeout,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] ID_IF = 2'd0;
  localparam logic [1:0] ID_LD = 2'd1;
  localparam logic [1:0] ID_WB = 2'd2;

  // Counter value of the last RD cycle allowed before the read is aborted.
  localparam logic [7:0] CNT_LAST = 8'(RD_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        win_q, win_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              if_ack_q, if_ack_d;
  logic              ld_ack_q, ld_ack_d;
  logic              wb_ack_q, wb_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              to_q, to_d;
  logic              busy_q, busy_d;

  logic              grant_any;
  logic [1:0]        grant_id;

  // Round-robin pick: scan starting at rr_q, in order fetch -> load -> wb.
  always_comb begin
    grant_any = if_req | ld_req | wb_req;
    grant_id  = ID_IF;
    case (rr_q)
      ID_IF: begin
        if (if_req)      grant_id = ID_IF;
        else if (ld_req) grant_id = ID_LD;
        else             grant_id = ID_WB;
      end
      ID_LD: begin
        if (ld_req)      grant_id = ID_LD;
        else if (wb_req) grant_id = ID_WB;
        else             grant_id = ID_IF;
      end
      default: begin
        if (wb_req)      grant_id = ID_WB;
        else if (if_req) grant_id = ID_IF;
        else             grant_id = ID_LD;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    ld_rdata_d = ld_rdata_q;
    rd_en_d    = rd_en_q;
    raddr_d    = raddr_q;
    we_d       = we_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    // Acks and the timeout flag are only ever high during DONE, which lasts
    // one cycle, so defaulting them low produces the one-cycle pulse.
    if_ack_d   = 1'b0;
    ld_ack_d   = 1'b0;
    wb_ack_d   = 1'b0;
    to_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          rr_d   = (grant_id == ID_WB) ? ID_IF : grant_id + 2'd1;
          win_d  = grant_id;
          cnt_d  = 8'd0;
          busy_d = 1'b1;
          if (grant_id == ID_WB) begin
            waddr_d = wb_addr;
            wdata_d = wb_wdata;
            we_d    = 1'b1;
            state_d = S_WR;
          end else begin
            raddr_d = (grant_id == ID_IF) ? if_addr : ld_addr;
            rd_en_d = 1'b1;
            state_d = S_RD;
          end
        end
      end

      S_WR: begin
        we_d     = 1'b0;
        wb_ack_d = 1'b1;
        state_d  = S_DONE;
      end

      S_RD: begin
        // Ready takes priority, so data arriving in the last allowed cycle
        // completes normally rather than timing out.
        if (sram_rdata_ready || (cnt_q == CNT_LAST)) begin
          rd_en_d = 1'b0;
          to_d    = ~sram_rdata_ready;
          state_d = S_DONE;
          if (win_q == ID_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = sram_rdata_ready ? sram_rdata : '0;
          end else begin
            ld_ack_d   = 1'b1;
            ld_rdata_d = sram_rdata_ready ? sram_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        // DONE: no grant here, so a requester's req is never re-sampled in
        // its own ack cycle.
        cnt_d   = 8'd0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= ID_IF;
      win_q      <= ID_IF;
      cnt_q      <= 8'd0;
      if_ack_q   <= 1'b0;
      ld_ack_q   <= 1'b0;
      wb_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
      rd_en_q    <= 1'b0;
      raddr_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      to_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      if_ack_q   <= if_ack_d;
      ld_ack_q   <= ld_ack_d;
      wb_ack_q   <= wb_ack_d;
      if_rdata_q <= if_rdata_d;
      ld_rdata_q <= ld_rdata_d;
      rd_en_q    <= rd_en_d;
      raddr_q    <= raddr_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      to_q       <= to_d;
      busy_q     <= busy_d;
    end
  end

  assign if_ack            = if_ack_q;
  assign if_rdata          = if_rdata_q;
  assign ld_ack            = ld_ack_q;
  assign ld_rdata          = ld_rdata_q;
  assign wb_ack            = wb_ack_q;
  assign sram_read_enable  = rd_en_q;
  assign sram_raddr        = raddr_q;
  assign sram_write_enable = we_q;
  assign sram_waddr        = waddr_q;
  assign sram_wdata        = wdata_q;
  assign rd_timeout        = to_q;
  assign busy              = busy_q;

endmodule
`default_nettype wire
